// File: rtl/uat_hex_formatter_if.sv
// Handshake bundle for uat_hex_formatter: 32-bit word input port and the byte
// port toward the uat transmitter (data/valid/busy).
interface uat_hex_formatter_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;

    modport master (
        output in_data, in_valid, tx_busy,
        input  in_ready, tx_data, tx_valid
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output in_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uat_hex_formatter.sv
// Queues 32-bit words and streams each one to uat as 8 ASCII hex digits plus a
// terminator, one byte per uat frame.
//
// state  | meaning
// S_IDLE | waiting for a queued word and a free uat
// S_SEND | tx_valid high for this single cycle
// S_WAIT | uat is framing the byte; advance to the next char once busy drops
module uat_hex_formatter #(
    parameter int DEPTH     = 16,
    parameter bit NEWLINE   = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    uat_hex_formatter_if.slave     bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   idle
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [3:0]    LAST = NEWLINE ? 4'd9 : 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    state_t        state_nxt;
    logic [31:0]   word_q;
    logic [31:0]   word_nxt;
    logic [3:0]    idx_q;
    logic [3:0]    idx_nxt;
    logic [7:0]    data_q;
    logic [7:0]    data_nxt;
    logic          valid_q;
    logic          valid_nxt;
    logic          push;
    logic          pop;

    // chars 0..7 are the nibbles MS first; 8 and 9 are the terminator bytes
    function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [3:0] i);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = w << {i[2:0], 2'b00};
        nib = sh[31:28];
        if (i == 4'd9)
            return 8'h0A;
        if (i == 4'd8)
            return NEWLINE ? 8'h0D : 8'h20;
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    endfunction

    assign bus.in_ready = (count != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == S_IDLE) && (count != '0) && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            word_q  <= word_nxt;
            idx_q   <= idx_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        idx_nxt   = idx_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    word_nxt  = mem[rd_ptr];
                    idx_nxt   = 4'd0;
                    data_nxt  = hex_char(mem[rd_ptr], 4'd0);
                    valid_nxt = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.tx_busy) begin
                    if (idx_q != LAST) begin
                        idx_nxt   = idx_q + 4'd1;
                        data_nxt  = hex_char(word_q, idx_q + 4'd1);
                        valid_nxt = 1'b1;
                        state_nxt = S_SEND;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.tx_data  = data_q;
    assign bus.tx_valid = valid_q;
    assign level        = count;
    assign idle         = (state == S_IDLE) && (count == '0);
endmodule

// File: tb/tb_uat_hex_formatter.sv
// Bench for uat_hex_formatter: two instances (upper/CRLF depth 16, lower/space depth 4)
// each driving a small uat model with randomized frame times.
module tb_uat_hex_formatter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uat_hex_formatter_if if_a ();
    uat_hex_formatter_if if_b ();
    logic [4:0] level_a;
    logic       idle_a;
    logic [2:0] level_b;
    logic       idle_b;

    uat_hex_formatter #(.DEPTH(16), .NEWLINE(1'b1), .UPPERCASE(1'b1)) u_a (
        .clk(clk), .resetn(resetn), .bus(if_a), .level(level_a), .idle(idle_a));
    uat_hex_formatter #(.DEPTH(4), .NEWLINE(1'b0), .UPPERCASE(1'b0)) u_b (
        .clk(clk), .resetn(resetn), .bus(if_b), .level(level_b), .idle(idle_b));

    int checks = 0;
    int errors = 0;

    // uat model state: frame countdown, forced busy, pulse counts
    int   cnt [2] = '{0, 0};
    logic hold [2] = '{1'b0, 1'b0};
    logic busy_seen [2] = '{1'b0, 1'b0};
    logic prev_valid [2] = '{1'b0, 1'b0};
    int   vcount [2] = '{0, 0};
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] got_a [$];
    logic [7:0] got_b [$];

    assign if_a.tx_busy = hold[0] | if_a.tx_valid | (cnt[0] != 0);
    assign if_b.tx_busy = hold[1] | if_b.tx_valid | (cnt[1] != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference: hex text of the word via string formatting, then the terminator
    function automatic void expect_word(input int ch, input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        if (ch == 0)
            s = s.toupper();
        for (int i = 0; i < 8; i++) begin
            if (ch == 0) exp_a.push_back(s[i]);
            else         exp_b.push_back(s[i]);
        end
        if (ch == 0) begin
            exp_a.push_back(8'h0D);
            exp_a.push_back(8'h0A);
        end else begin
            exp_b.push_back(8'h20);
        end
    endfunction

    always @(posedge clk) begin
        busy_seen[0] <= if_a.tx_busy;
        busy_seen[1] <= if_b.tx_busy;
    end

    task automatic uat_step(input int ch, input logic v, input logic [7:0] d);
        logic [7:0] e;
        if (cnt[ch] != 0)
            cnt[ch] = cnt[ch] - 1;
        if (v) begin
            vcount[ch]++;
            check("valid_after_busy", {31'b0, busy_seen[ch]}, 0);
            check("valid_one_cycle", {31'b0, prev_valid[ch]}, 0);
            cnt[ch] = $urandom_range(1, 6);
            if (ch == 0) got_a.push_back(d);
            else         got_b.push_back(d);
            if ((ch == 0 && exp_a.size() == 0) || (ch == 1 && exp_b.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte ch%0d: got %02h, expected none", ch, d);
            end else begin
                e = (ch == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check($sformatf("byte_ch%0d", ch), {24'b0, d}, {24'b0, e});
            end
        end
        prev_valid[ch] = v;
    endtask

    always @(negedge clk) begin
        uat_step(0, if_a.tx_valid, if_a.tx_data);
        uat_step(1, if_b.tx_valid, if_b.tx_data);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input int ch, input logic v, input logic [31:0] d);
        if (ch == 0) begin if_a.in_valid = v; if_a.in_data = d; end
        else         begin if_b.in_valid = v; if_b.in_data = d; end
    endtask

    task automatic push(input int ch, input logic [31:0] w);
        int t;
        t = 0;
        tick();
        while (((ch == 0) ? !if_a.in_ready : !if_b.in_ready) && t < 5000) begin
            tick();
            t++;
        end
        check("push_timeout", (t < 5000) ? 32'd1 : 32'd0, 1);
        set_in(ch, 1'b1, w);
        expect_word(ch, w);
        tick();
        set_in(ch, 1'b0, 32'h0);
    endtask

    task automatic drain(input int ch);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!((ch == 0) ? (idle_a && exp_a.size() == 0) : (idle_b && exp_b.size() == 0))
                   && t < 20000);
        check("drain_timeout", (t < 20000) ? 32'd1 : 32'd0, 1);
    endtask

    typedef struct {
        int          ch;
        logic [31:0] word;
        int          nbytes;
        logic [79:0] bytes;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wl [20];
        logic [31:0] w;
        int n;
        int v0;
        logic [7:0] eb;

        vecs[0] = '{0, 32'hDEADBEEF, 10, 80'h4445_4144_4245_4546_0D0A};
        vecs[1] = '{1, 32'h0A1B2C3F,  9, 80'h0030_6131_6232_6333_6620};
        vecs[2] = '{0, 32'h0123ABCD, 10, 80'h3031_3233_4142_4344_0D0A};
        vecs[3] = '{1, 32'h9876FEDC,  9, 80'h0039_3837_3666_6564_6320};
        vecs[4] = '{0, 32'hFFFFFFFF, 10, 80'h4646_4646_4646_4646_0D0A};
        vecs[5] = '{1, 32'h00000000,  9, 80'h0030_3030_3030_3030_3020};

        set_in(0, 1'b0, 32'h0);
        set_in(1, 1'b0, 32'h0);
        tick();
        check("rst_level_a", {27'b0, level_a}, 0);
        check("rst_idle_a", {31'b0, idle_a}, 1);
        check("rst_ready_a", {31'b0, if_a.in_ready}, 1);
        check("rst_valid_a", {31'b0, if_a.tx_valid}, 0);
        check("rst_data_a", {24'b0, if_a.tx_data}, 0);
        check("rst_level_b", {29'b0, level_b}, 0);
        resetn = 1'b1;
        tick();

        // table-driven lines
        foreach (vecs[i]) begin
            if (vecs[i].ch == 0) got_a.delete(); else got_b.delete();
            v0 = vcount[vecs[i].ch];
            push(vecs[i].ch, vecs[i].word);
            drain(vecs[i].ch);
            check($sformatf("pulses_v%0d", i), vcount[vecs[i].ch] - v0, vecs[i].nbytes);
            for (int k = 0; k < vecs[i].nbytes; k++) begin
                eb = vecs[i].bytes[8 * (vecs[i].nbytes - 1 - k) +: 8];
                if (k < ((vecs[i].ch == 0) ? got_a.size() : got_b.size()))
                    check($sformatf("line_v%0d_b%0d", i, k),
                          {24'b0, (vecs[i].ch == 0) ? got_a[k] : got_b[k]}, {24'b0, eb});
            end
        end

        // latency: push into empty FIFO, tx_valid high in the cycle after E+1
        tick();
        set_in(0, 1'b1, 32'hC0FFEE00);
        expect_word(0, 32'hC0FFEE00);
        tick();
        set_in(0, 1'b0, 32'h0);
        check("lat_valid_e", {31'b0, if_a.tx_valid}, 0);
        check("lat_level_e", {27'b0, level_a}, 1);
        tick();
        check("lat_valid_e1", {31'b0, if_a.tx_valid}, 1);
        check("lat_level_e1", {27'b0, level_a}, 0);
        check("lat_data_e1", {24'b0, if_a.tx_data}, 32'h43);
        drain(0);

        // uat held busy: FIFO fills to 16, nothing sent
        hold[0] = 1'b1;
        v0 = vcount[0];
        for (int i = 0; i < 20; i++) wl[i] = $urandom;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            set_in(0, 1'b1, wl[n]);
            if (if_a.in_ready) begin
                expect_word(0, wl[n]);
                n++;
            end
        end
        tick();
        set_in(0, 1'b0, 32'h0);
        check("full_accepted", n, 16);
        check("full_level", {27'b0, level_a}, 16);
        check("full_ready", {31'b0, if_a.in_ready}, 0);
        check("full_no_valid", vcount[0] - v0, 0);
        got_a.delete();
        hold[0] = 1'b0;
        drain(0);
        check("full_bytes", got_a.size(), 160);

        // simultaneous push and pop at level 3
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++) push(0, $urandom);
        tick();
        check("pp_level_before", {27'b0, level_a}, 3);
        hold[0] = 1'b0;
        set_in(0, 1'b1, 32'h13579BDF);
        expect_word(0, 32'h13579BDF);
        tick();
        set_in(0, 1'b0, 32'h0);
        check("pp_level_after", {27'b0, level_a}, 3);
        check("pp_popped", {31'b0, if_a.tx_valid}, 1);
        drain(0);

        // random wrap-around traffic, 3x depth on each instance
        for (int i = 0; i < 48; i++) begin
            push(0, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain(0);
        for (int i = 0; i < 12; i++) begin
            w = $urandom;
            push(1, w);
        end
        drain(1);

        // reset during char index 4 abandons the line
        got_a.delete();
        push(0, 32'h12345678);
        push(0, 32'h9ABCDEF0);
        n = 0;
        while (got_a.size() < 5 && n < 5000) begin
            tick();
            n++;
        end
        check("mid_reach_idx4", {31'b0, if_a.tx_valid}, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("mid_valid", {31'b0, if_a.tx_valid}, 0);
        check("mid_level", {27'b0, level_a}, 0);
        check("mid_idle", {31'b0, idle_a}, 1);
        exp_a.delete();
        tick();
        tick();
        resetn = 1'b1;
        got_a.delete();
        push(0, 32'h00000001);
        drain(0);
        check("post_rst_count", got_a.size(), 10);
        for (int k = 0; k < 10 && k < got_a.size(); k++)
            check($sformatf("post_rst_b%0d", k), {24'b0, got_a[k]},
                  (k < 7) ? 32'h30 : (k == 7) ? 32'h31 : (k == 8) ? 32'h0D : 32'h0A);

        check("exp_a_empty", exp_a.size(), 0);
        check("exp_b_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
